// File: rtl/genius_pkg.sv
// Shared types and helpers for the parametrised memory game.
// State codes are visible on db_estado, so their values are fixed here.
package genius_pkg;

   typedef enum logic [3:0] {
      INICIAL     = 4'd0,
      PREPARA     = 4'd1,
      MOSTRA      = 4'd2,
      PAUSA       = 4'd3,
      ESPERA      = 4'd4,
      REGISTRA    = 4'd5,
      COMPARA     = 4'd6,
      PROXIMA     = 4'd7,
      ESPERA_NOVA = 4'd8,
      GRAVA_NOVA  = 4'd9,
      FIM_GANHOU  = 4'd10,
      FIM_PERDEU  = 4'd11,
      FIM_TIMEOUT = 4'd12
   } estado_t;

   localparam int                LFSR_W    = 16;
   // Fibonacci taps 16,14,13,11 as a mask over bits [15:0]
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   function automatic logic [7:0] onehot_of(input logic [2:0] idx);
      return 8'b1 << idx;
   endfunction

endpackage

// File: rtl/genius_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes the low byte used to draw entries.
module genius_lfsr
   import genius_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
   input  logic       clock_i,
   input  logic       reset_i,
   output logic [7:0] sorteio_o
);

   logic [LFSR_W-1:0] lfsr_q;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) lfsr_q <= SEED;
      else          lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
   end

   assign sorteio_o = lfsr_q[7:0];

endmodule

// File: rtl/genius_param.sv
// Memory-game controller: configurable button count, depth and timing, with
// player-built (modo=0) or LFSR-generated (modo=1) sequences. reset_i is active-low.
module genius_param
   import genius_pkg::*;
#(
   parameter int          N_BOTOES = 4,
   parameter int          DEPTH    = 16,
   parameter int          TIMEOUT  = 5000,
   parameter int          SHOW     = 1000,
   parameter int          GAP      = 500,
   parameter int          FIRST    = 1,
   parameter logic [15:0] SEED     = 16'hACE1,
   localparam int         RW       = $clog2(DEPTH)
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                iniciar_i,
   input  logic                modo_i,
   input  logic [N_BOTOES-1:0] botoes_i,
   output logic [N_BOTOES-1:0] leds_o,
   output logic                pronto_o,
   output logic                ganhou_o,
   output logic                perdeu_o,
   output logic                timeout_o,
   output logic [RW-1:0]       db_rodada_o,
   output logic [RW-1:0]       db_endereco_o,
   output logic [N_BOTOES-1:0] db_memoria_o,
   output logic [3:0]          db_estado_o
);

   localparam int TMAX = (TIMEOUT > SHOW) ? ((TIMEOUT > GAP) ? TIMEOUT : GAP)
                                          : ((SHOW > GAP) ? SHOW : GAP);
   localparam int TW   = $clog2(TMAX + 1);

   estado_t             estado_q;
   logic [RW-1:0]       rodada_q, endereco_q;
   logic [TW-1:0]       cnt_q;
   logic [N_BOTOES-1:0] botoes_q, jogada_q;
   logic                modo_q;
   logic [N_BOTOES-1:0] mem_q [DEPTH];

   logic [7:0]          lfsr_lo;
   logic [N_BOTOES-1:0] sorteio;
   logic                tem_jogada, jogada_ok;
   logic                we;
   logic [RW-1:0]       waddr;
   logic [N_BOTOES-1:0] wdata;

   genius_lfsr #(.SEED(SEED)) u_lfsr (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .sorteio_o (lfsr_lo)
   );

   assign sorteio    = N_BOTOES'(onehot_of(3'(lfsr_lo % 8'(N_BOTOES))));
   assign tem_jogada = (|botoes_i) & ~(|botoes_q);
   assign jogada_ok  = (|jogada_q) & ~(|(jogada_q & (jogada_q - 1'b1)));

   always_comb begin
      we    = 1'b0;
      waddr = endereco_q;
      wdata = sorteio;
      if (estado_q == PREPARA) begin
         we = 1'b1;
         if (!modo_q) begin
            waddr = '0;
            wdata = N_BOTOES'(FIRST);
         end
      end else if (estado_q == GRAVA_NOVA && jogada_ok) begin
         we    = 1'b1;
         waddr = rodada_q + 1'b1;
         wdata = jogada_q;
      end
   end

   always_ff @(posedge clock_i) begin
      if (we) mem_q[waddr] <= wdata;
   end

   // One shared timer: cleared on every entry to a timed state, free-running elsewhere.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         estado_q   <= INICIAL;
         rodada_q   <= '0;
         endereco_q <= '0;
         cnt_q      <= '0;
         botoes_q   <= '0;
         jogada_q   <= '0;
         modo_q     <= 1'b0;
      end else begin
         botoes_q <= botoes_i;
         cnt_q    <= cnt_q + 1'b1;
         unique case (estado_q)
            INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT:
               if (iniciar_i) begin
                  estado_q   <= PREPARA;
                  rodada_q   <= '0;
                  endereco_q <= '0;
                  modo_q     <= modo_i;
               end
            PREPARA: begin
               cnt_q <= '0;
               if (!modo_q || endereco_q == RW'(DEPTH-1)) begin
                  endereco_q <= '0;
                  estado_q   <= MOSTRA;
               end else begin
                  endereco_q <= endereco_q + 1'b1;
               end
            end
            MOSTRA:
               if (cnt_q == TW'(SHOW-1)) begin
                  cnt_q    <= '0;
                  estado_q <= PAUSA;
               end
            PAUSA:
               if (cnt_q == TW'(GAP-1)) begin
                  cnt_q <= '0;
                  if (endereco_q == rodada_q) begin
                     endereco_q <= '0;
                     estado_q   <= ESPERA;
                  end else begin
                     endereco_q <= endereco_q + 1'b1;
                     estado_q   <= MOSTRA;
                  end
               end
            // a press on the expiry cycle takes priority over the timeout
            ESPERA, ESPERA_NOVA:
               if (tem_jogada) begin
                  jogada_q <= botoes_i;
                  estado_q <= (estado_q == ESPERA) ? REGISTRA : GRAVA_NOVA;
               end else if (cnt_q == TW'(TIMEOUT-1)) begin
                  estado_q <= FIM_TIMEOUT;
               end
            REGISTRA: estado_q <= COMPARA;
            COMPARA: begin
               cnt_q <= '0;
               if (jogada_q != mem_q[endereco_q]) begin
                  estado_q <= FIM_PERDEU;
               end else if (endereco_q != rodada_q) begin
                  endereco_q <= endereco_q + 1'b1;
                  estado_q   <= ESPERA;
               end else begin
                  estado_q <= PROXIMA;
               end
            end
            PROXIMA: begin
               cnt_q <= '0;
               if (rodada_q == RW'(DEPTH-1)) begin
                  estado_q <= FIM_GANHOU;
               end else if (modo_q) begin
                  rodada_q   <= rodada_q + 1'b1;
                  endereco_q <= '0;
                  estado_q   <= MOSTRA;
               end else begin
                  estado_q <= ESPERA_NOVA;
               end
            end
            GRAVA_NOVA: begin
               cnt_q <= '0;
               if (jogada_ok) begin
                  rodada_q   <= rodada_q + 1'b1;
                  endereco_q <= '0;
                  estado_q   <= MOSTRA;
               end else begin
                  estado_q <= FIM_PERDEU;
               end
            end
            default: estado_q <= INICIAL;
         endcase
      end
   end

   always_comb begin
      leds_o = '0;
      case (estado_q)
         MOSTRA:                        leds_o = mem_q[endereco_q];
         REGISTRA, COMPARA, GRAVA_NOVA: leds_o = jogada_q;
         default:                       ;
      endcase
   end

   assign pronto_o      = estado_q inside {FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT};
   assign ganhou_o      = (estado_q == FIM_GANHOU);
   assign perdeu_o      = estado_q inside {FIM_PERDEU, FIM_TIMEOUT};
   assign timeout_o     = (estado_q == FIM_TIMEOUT);
   assign db_rodada_o   = rodada_q;
   assign db_endereco_o = endereco_q;
   // memory is unreset, so hide its contents until a game has been prepared
   assign db_memoria_o  = (estado_q == INICIAL) ? '0 : mem_q[endereco_q];
   assign db_estado_o   = estado_q;

endmodule

// File: tb/tb_genius_param.sv
// Scoreboarded bench for genius_param: modes 0/1, win, loss, timeout, reset.
module tb_genius_param;

   logic       clock_i = 1'b0;
   logic       reset_i = 1'b0;
   logic       iniciar_i = 1'b0;
   logic       modo_i = 1'b0;
   logic [3:0] botoes_i = '0;
   logic [3:0] leds_o, db_memoria_o, db_estado_o;
   logic       pronto_o, ganhou_o, perdeu_o, timeout_o;
   logic [1:0] db_rodada_o, db_endereco_o;

   int         n_chk = 0;
   int         n_fail = 0;
   logic [3:0] exp_q[$];
   logic [3:0] exp_mem[4];
   logic [3:0] newp[3] = '{4'b0010, 4'b1000, 4'b0100};

   genius_param #(
      .N_BOTOES(4), .DEPTH(4), .TIMEOUT(50), .SHOW(10), .GAP(5)
   ) dut (
      .clock_i(clock_i), .reset_i(reset_i), .iniciar_i(iniciar_i), .modo_i(modo_i),
      .botoes_i(botoes_i), .leds_o(leds_o), .pronto_o(pronto_o), .ganhou_o(ganhou_o),
      .perdeu_o(perdeu_o), .timeout_o(timeout_o), .db_rodada_o(db_rodada_o),
      .db_endereco_o(db_endereco_o), .db_memoria_o(db_memoria_o), .db_estado_o(db_estado_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic wait_st(input int s);
      int n = 0;
      while (int'(db_estado_o) != s && n < 300) begin
         step();
         n++;
      end
      if (n == 300) chk("wait_st", db_estado_o, s);
   endtask

   task automatic start(input bit m);
      if (!m) exp_mem[0] = 4'b0001;
      iniciar_i = 1'b1;
      modo_i    = m;
      step();
      iniciar_i = 1'b0;
      chk("start_st", db_estado_o, 1);
      chk("start_rod", db_rodada_o, 0);
   endtask

   // Drive one press edge; the echo is scoreboarded and checked when REGISTRA/GRAVA_NOVA appears.
   task automatic press(input logic [3:0] v, input int st);
      botoes_i = v;
      exp_q.push_back(v);
      step();
      botoes_i = '0;
      chk("reg_st", db_estado_o, st);
   endtask

   task automatic show_round(input int r, input bit m, input logic [3:0] hold);
      int n;
      for (int i = 0; i <= r; i++) begin
         wait_st(2);
         if (m && i == r) begin
            chk("m1_onehot", int'($onehot(leds_o)), 1);
            exp_mem[i] = leds_o;
         end else begin
            chk($sformatf("show%0d_%0d", r, i), leds_o, exp_mem[i]);
         end
         if (hold != 0 && i == r) botoes_i = hold;
         n = 1;
         while (n < 100) begin
            step();
            if (db_estado_o != 4'd2) break;
            n++;
         end
         chk("show_len", n, 10);
      end
      wait_st(4);
   endtask

   task automatic run_win(input bit m, input logic [3:0] hold);
      for (int r = 0; r < 4; r++) begin
         show_round(r, m, (r == 1) ? hold : 4'b0);
         if (r == 1 && hold != 0) begin
            repeat (5) step();
            chk("held_ign", db_estado_o, 4);
            botoes_i = '0;
            step();
         end
         for (int i = 0; i <= r; i++) begin
            wait_st(4);
            press(exp_mem[i], 5);
            step();
            chk("compara", db_estado_o, 6);
            step();
            chk("outcome", db_estado_o, (i < r) ? 4 : 7);
         end
         step();
         if (r == 3) begin
            chk("win_st", db_estado_o, 10);
            chk("win_ganhou", ganhou_o, 1);
            chk("win_pronto", pronto_o, 1);
            chk("win_perdeu", perdeu_o, 0);
         end else if (m) begin
            chk("m1_next", db_estado_o, 2);
            chk("m1_rod", db_rodada_o, r + 1);
         end else begin
            chk("nova_st", db_estado_o, 8);
            press(newp[r], 9);
            exp_mem[r+1] = newp[r];
            step();
            chk("grava_st", db_estado_o, 2);
            chk("grava_rod", db_rodada_o, r + 1);
         end
      end
   endtask

   always @(negedge clock_i) begin
      if (reset_i && (db_estado_o == 4'd5 || db_estado_o == 4'd9)) begin
         if (exp_q.size() == 0) chk("sb_pending", exp_q.size(), 1);
         else                   chk("echo", leds_o, exp_q.pop_front());
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) step();
      chk("rst_st", db_estado_o, 0);
      chk("rst_leds", leds_o, 0);
      chk("rst_flags", {pronto_o, ganhou_o, perdeu_o, timeout_o}, 0);
      chk("rst_rod", db_rodada_o, 0);
      chk("rst_end", db_endereco_o, 0);
      chk("rst_mem", db_memoria_o, 0);
      reset_i = 1'b1;
      step();

      // mode 0 loss on the second round
      start(0);
      show_round(0, 0, 4'b0);
      press(4'b0001, 5);
      step(); chk("l_cmp", db_estado_o, 6);
      step(); chk("l_prox", db_estado_o, 7);
      step(); chk("l_nova", db_estado_o, 8);
      press(4'b0100, 9);
      exp_mem[1] = 4'b0100;
      step(); chk("l_mostra", db_estado_o, 2);
      show_round(1, 0, 4'b0);
      press(4'b0001, 5);
      step(); step(); chk("l_next", db_estado_o, 4);
      press(4'b0010, 5);
      step(); chk("l_cmp2", db_estado_o, 6);
      step();
      chk("l_st", db_estado_o, 11);
      chk("l_flags", {pronto_o, ganhou_o, perdeu_o, timeout_o}, 4'b1010);

      // mode 0 win, restarting from FIM
      start(0);
      run_win(0, 4'b0);

      // mode 1 win, with a button held from MOSTRA into ESPERA
      start(1);
      run_win(1, 4'b0010);

      // timeout after exactly 50 idle cycles
      start(0);
      show_round(0, 0, 4'b0);
      repeat (49) step();
      chk("to_wait", db_estado_o, 4);
      step();
      chk("to_st", db_estado_o, 12);
      chk("to_flags", {pronto_o, ganhou_o, perdeu_o, timeout_o}, 4'b1011);

      // press on the expiry cycle wins
      start(0);
      show_round(0, 0, 4'b0);
      repeat (49) step();
      press(4'b0001, 5);
      step(); step();
      chk("late_st", db_estado_o, 7);
      chk("late_to", timeout_o, 0);
      step();
      chk("late_nova", db_estado_o, 8);
      iniciar_i = 1'b1;
      step();
      iniciar_i = 1'b0;
      chk("ini_ign", db_estado_o, 8);
      wait_st(12);
      chk("nova_to", timeout_o, 1);

      // non-one-hot play is a loss
      start(0);
      show_round(0, 0, 4'b0);
      press(4'b0011, 5);
      step(); step();
      chk("nh_st", db_estado_o, 11);
      chk("nh_perdeu", perdeu_o, 1);

      // asynchronous reset mid-MOSTRA
      start(0);
      wait_st(2);
      repeat (3) step();
      chk("pre_rst_leds", leds_o, 1);
      reset_i = 1'b0;
      #1;
      chk("arst_st", db_estado_o, 0);
      chk("arst_leds", leds_o, 0);
      chk("arst_flags", {pronto_o, ganhou_o, perdeu_o, timeout_o}, 0);
      step();
      reset_i = 1'b1;
      step();

      chk("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/genius_param.md
# genius_param

Parametrised successor of the memory-game (Genius/Simon) circuit. Sits between the panel buttons/LEDs and the top-level, replacing the fixed 4-button, fixed-depth controller. It generalises button count, sequence depth, timeout and display timing. It adds two sequence modes: player-built (each round the player appends a new play) and LFSR-generated.

## Interface
- N_BOTOES, 4 — buttons/LEDs, 2..8.
- DEPTH, 16 — rounds to win, 2..64; memory entries.
- TIMEOUT, 5000 — cycles allowed per play before loss.
- SHOW, 1000 — cycles each entry is lit during display.
- GAP, 500 — dark cycles between displayed entries.
- FIRST, 1 — one-hot entry 0 in mode 0.
- SEED, 16'hACE1 — LFSR reset value, nonzero.
- clock in 1 — single clock, rising edge.
- reset in 1 — asynchronous, active-low.
- iniciar in 1 — start/restart pulse, level-sampled.
- modo in 1 — 0 player-built, 1 LFSR; sampled when leaving INICIAL/FIM.
- botoes in N_BOTOES — raw buttons (already synchronised upstream).
- leds out N_BOTOES — display/echo.
- pronto, ganhou, perdeu, timeout out 1 — game-end flags.
- db_rodada, db_endereco out RW=$clog2(DEPTH) — current round/address.
- db_memoria out N_BOTOES — memory data at db_endereco.
- db_estado out 4 — FSM code.

## Operation
- Play detect: tem_jogada = |botoes & ~|botoes_d. A button held across states never counts twice. A non-one-hot value is a wrong play.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every cycle from reset. Entry = one-hot of (lfsr[7:0] % N_BOTOES).
- States: INICIAL(0), PREPARA, MOSTRA, PAUSA, ESPERA, REGISTRA, COMPARA, PROXIMA, ESPERA_NOVA, GRAVA_NOVA, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT.
- INICIAL/FIM_* + iniciar → PREPARA:
  - clear rodada and endereco; latch modo.
  - Mode 0: write FIRST to entry 0 (1 cycle).
  - Mode 1: write DEPTH LFSR entries, one per cycle.
- MOSTRA → PAUSA → …: show entries 0..rodada, SHOW lit and GAP dark each. Then ESPERA with endereco=0.
- ESPERA: timeout counter runs.
  - tem_jogada → REGISTRA: latch botoes.
  - TIMEOUT cycles with no play → FIM_TIMEOUT.
- COMPARA:
  - mismatch → FIM_PERDEU.
  - match and endereco<rodada → endereco+1, ESPERA.
  - match and endereco==rodada → PROXIMA.
- PROXIMA:
  - rodada==DEPTH-1 → FIM_GANHOU.
  - mode 1 → rodada+1, MOSTRA.
  - mode 0 → ESPERA_NOVA.
- ESPERA_NOVA: same timeout rule. Play → GRAVA_NOVA: write play at rodada+1 (any one-hot accepted; non-one-hot → FIM_PERDEU), rodada+1, MOSTRA.
- leds: entry during MOSTRA; latched play during REGISTRA/COMPARA/GRAVA_NOVA; 0 otherwise.
- Flags:
  - pronto=1 in all FIM_*.
  - ganhou=1 only in FIM_GANHOU.
  - perdeu=1 in FIM_PERDEU and FIM_TIMEOUT.
  - timeout=1 only in FIM_TIMEOUT.
- iniciar is ignored outside INICIAL/FIM_*.

## Timing
- Reset (asynchronous, immediate, also mid-game):
  - state INICIAL, db_estado=0.
  - all outputs 0; counters 0; memory contents undefined.
  - lfsr=SEED.
- Play latency: edge seen at clock k → REGISTRA after k. Then COMPARA after k+1. Then outcome state (flags valid) after k+2.
- Timeout: counter clears on every entry to ESPERA/ESPERA_NOVA. Loss after exactly TIMEOUT cycles there.
- A press on the same cycle as timeout expiry: the press wins.
- MOSTRA entry 0 lit for exactly SHOW cycles.
- Counters are RW bits wide. rodada never wraps: win is checked before increment.

## Structure
- Package genius_pkg: state enum (4-bit codes), LFSR taps and width, onehot_of(index) function.
- Sub-module genius_lfsr: free-running 16-bit LFSR with SEED parameter and reset.
- Memory, timers and FSM stay in the top module.

## Test plan
All tests use N_BOTOES=4, DEPTH=4, TIMEOUT=50, SHOW=10, GAP=5.
- reset low mid-MOSTRA → db_estado=0, leds=0, flags 0 that cycle.
- Mode 0 loss:
  - iniciar; leds show 0001.
  - press 0001, then new play 0100.
  - round 2 shows 0001, 0100.
  - press 0001, then 0010 → perdeu=1, pronto=1, timeout=0, ganhou=0, 2 cycles after the press edge.
- Mode 0 win: four correct rounds → ganhou=1 with no ESPERA_NOVA after round 3.
- Timeout:
  - no press for 50 cycles in ESPERA → timeout=1, perdeu=1.
  - press on cycle 50 → no timeout.
- Mode 1: entries captured from leds are replayed correctly, DEPTH rounds → ganhou. A button held from MOSTRA into ESPERA does not register.
- Input 0011 pressed in ESPERA → FIM_PERDEU. iniciar from FIM → PREPARA with rodada=0.
